// File: rtl/difftest_int_wb_batcher.sv
// Integer-writeback difftest batcher.
// Samples up to NUM_PORTS writebacks per cycle, stamps them with a free-running
// cycle counter and queues each cycle's live writebacks as one FIFO entry that
// drains over a valid/ready stream towards the difftest transport.
module difftest_int_wb_batcher #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 8,
    parameter int FILTER_ZERO = 1,
    parameter int TS_W        = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [7:0]                    io_coreid,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   in_address,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_PORTS-1:0]          out_mask,
    output logic [NUM_PORTS*ADDR_W-1:0]   out_address,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [7:0]                    out_coreid,
    output logic [TS_W-1:0]               out_cycle,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int AW_ALL = NUM_PORTS * ADDR_W;
    localparam int DW_ALL = NUM_PORTS * DATA_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    // A lane is live when capture is enabled, the port is valid and, with
    // zero filtering on, it does not target the hard-wired zero register.
    function automatic logic lane_live(input logic en, input logic vld,
                                       input logic [ADDR_W-1:0] addr);
        logic zero_hit;
        zero_hit = (FILTER_ZERO != 0) && (addr == '0);
        return en & vld & ~zero_hit;
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Entry storage, one slot per FIFO position.
    logic [NUM_PORTS-1:0] mem_mask   [DEPTH];
    logic [AW_ALL-1:0]    mem_addr   [DEPTH];
    logic [DW_ALL-1:0]    mem_data   [DEPTH];
    logic [7:0]           mem_coreid [DEPTH];
    logic [TS_W-1:0]      mem_cycle  [DEPTH];

    // Control state.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [TS_W-1:0]  cycle_cnt;

    // Capture-side combinational values.
    logic [NUM_PORTS-1:0] cap_mask;
    logic [AW_ALL-1:0]    cap_addr;
    logic [DW_ALL-1:0]    cap_data;

    logic head_valid;
    logic deq;
    logic enq_req;
    logic has_room;
    logic enq_ok;
    logic drop;

    // Build the live mask; dead lanes carry zero address and data.
    always_comb begin
        cap_mask = '0;
        cap_addr = '0;
        cap_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (lane_live(enable, in_valid[i], in_address[i*ADDR_W +: ADDR_W])) begin
                cap_mask[i]                   = 1'b1;
                cap_addr[i*ADDR_W +: ADDR_W]  = in_address[i*ADDR_W +: ADDR_W];
                cap_data[i*DATA_W +: DATA_W]  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake decisions. A full FIFO still accepts when the head leaves in
    // the same cycle; an empty FIFO can never dequeue.
    always_comb begin
        head_valid = (occupancy != '0);
        deq        = head_valid & out_ready;
        enq_req    = |cap_mask;
        has_room   = (occupancy < DEPTH_OCC);
        enq_ok     = enq_req & (has_room | deq);
        drop       = enq_req & ~enq_ok;
    end

    // Pointers, occupancy, cycle stamp and overflow bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            cycle_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (enq_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq_ok, deq})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
        end
    end

    // Entry write; payload storage needs no reset because occupancy gates it.
    always_ff @(posedge clock) begin
        if (enq_ok) begin
            mem_mask[wr_ptr]   <= cap_mask;
            mem_addr[wr_ptr]   <= cap_addr;
            mem_data[wr_ptr]   <= cap_data;
            mem_coreid[wr_ptr] <= io_coreid;
            mem_cycle[wr_ptr]  <= cycle_cnt;
        end
    end

    // Head presentation, forced to zero while the FIFO is empty.
    always_comb begin
        out_valid   = head_valid;
        out_mask    = '0;
        out_address = '0;
        out_data    = '0;
        out_coreid  = '0;
        out_cycle   = '0;
        if (head_valid) begin
            out_mask    = mem_mask[rd_ptr];
            out_address = mem_addr[rd_ptr];
            out_data    = mem_data[rd_ptr];
            out_coreid  = mem_coreid[rd_ptr];
            out_cycle   = mem_cycle[rd_ptr];
        end
    end

endmodule

// File: tb/tb_difftest_int_wb_batcher.sv
// Randomised and directed bench for difftest_int_wb_batcher with a queue model.
module tb_difftest_int_wb_batcher;

    localparam int NP = 2;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int DEPTH = 8;
    localparam int VW = 1 + NP + NP*AW + NP*DW + 8 + 32 + 4 + 1 + 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           enable = 1'b0;
    logic [7:0]     io_coreid = 8'h0;
    logic [NP-1:0]  in_valid = '0;
    logic [NP*AW-1:0] in_address = '0;
    logic [NP*DW-1:0] in_data = '0;
    logic           out_ready = 1'b0;
    logic           out_valid;
    logic [NP-1:0]  out_mask;
    logic [NP*AW-1:0] out_address;
    logic [NP*DW-1:0] out_data;
    logic [7:0]     out_coreid;
    logic [31:0]    out_cycle;
    logic [3:0]     occupancy;
    logic           overflow;
    logic [15:0]    drop_count;

    difftest_int_wb_batcher #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
        .FILTER_ZERO(1), .TS_W(32)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .io_coreid(io_coreid),
        .in_valid(in_valid), .in_address(in_address), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_address(out_address), .out_data(out_data), .out_coreid(out_coreid),
        .out_cycle(out_cycle), .occupancy(occupancy), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [NP-1:0]    mask;
        logic [NP*AW-1:0] addr;
        logic [NP*DW-1:0] data;
        logic [7:0]       core;
        logic [31:0]      cyc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_cnt = 0;
    logic        m_ovf = 0;
    int          m_drops = 0;

    logic [VW-1:0] obs;
    assign obs = {out_valid, out_mask, out_address, out_data, out_coreid,
                  out_cycle, occupancy, overflow, drop_count};

    // Model: a plain queue of entries, updated once per rising edge.
    task automatic model_step();
        ent_t e;
        bit   deq;
        bit   acc;
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_drops = 0;
        end else begin
            e.mask = '0; e.addr = '0; e.data = '0;
            e.core = io_coreid;
            e.cyc  = m_cnt;
            for (int i = 0; i < NP; i++) begin
                if (enable && in_valid[i] && in_address[i*AW +: AW] != 0) begin
                    e.mask[i] = 1'b1;
                    e.addr[i*AW +: AW] = in_address[i*AW +: AW];
                    e.data[i*DW +: DW] = in_data[i*DW +: DW];
                end
            end
            deq = (q.size() > 0) && out_ready;
            acc = (q.size() < DEPTH) || deq;
            if (deq) void'(q.pop_front());
            if (e.mask != 0) begin
                if (acc) q.push_back(e);
                else begin
                    m_ovf = 1;
                    m_drops++;
                end
            end
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [15:0] dc;
        dc = (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
        if (q.size() != 0)
            return {1'b1, q[0].mask, q[0].addr, q[0].data, q[0].core, q[0].cyc,
                    4'(q.size()), m_ovf, dc};
        return {1'b0, {NP{1'b0}}, {(NP*AW){1'b0}}, {(NP*DW){1'b0}}, 8'h0, 32'h0,
                4'h0, m_ovf, dc};
    endfunction

    // One clock: model follows the edge, outputs are then sampled at negedge.
    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic set_in(input logic en, input logic [1:0] v, input logic [4:0] a0,
                          input logic [4:0] a1, input logic [63:0] d0,
                          input logic [63:0] d1, input logic rdy);
        enable = en;
        in_valid = v;
        in_address = {a1, a0};
        in_data = {d1, d0};
        out_ready = rdy;
    endtask

    task automatic do_reset();
        set_in(0, 2'b00, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        do_reset();
        repeat (10) cycle();
        checks++;
        if ({out_valid, occupancy, overflow, drop_count, out_cycle} !== '0) begin
            fails++;
            $display("FAIL reset_idle got v=%b occ=%0d ovf=%b drops=%0d cyc=%0d want all 0",
                     out_valid, occupancy, overflow, drop_count, out_cycle);
        end
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL reset_model got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_basic();
        do_reset();
        io_coreid = 8'h5A;
        repeat (3) cycle();
        set_in(1, 2'b11, 5'd5, 5'd0, 64'h1111, 64'h2222, 0);
        cycle();
        set_in(0, 2'b00, 0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_mask !== 2'b01 || occupancy !== 4'd1) begin
            fails++;
            $display("FAIL basic_head got v=%b mask=%b occ=%0d want v=1 mask=01 occ=1",
                     out_valid, out_mask, occupancy);
        end
        checks++;
        if (out_address !== {5'd0, 5'd5} || out_data !== {64'h0, 64'h1111}) begin
            fails++;
            $display("FAIL basic_lanes got addr=%h data=%h want addr=005 data=0..01111",
                     out_address, out_data);
        end
        checks++;
        if (out_cycle !== 32'd3 || out_coreid !== 8'h5A) begin
            fails++;
            $display("FAIL basic_stamp got cyc=%0d core=%h want cyc=3 core=5a",
                     out_cycle, out_coreid);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0 || obs !== exp_vec()) begin
            fails++;
            $display("FAIL basic_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 2'b01, 5'd1, 5'($urandom), r64(), r64(), 0);
            cycle();
        end
        set_in(0, 2'b00, 0, 0, 0, 0, 0);
        checks++;
        if (occupancy !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            fails++;
            $display("FAIL ovf_state got occ=%0d ovf=%b drops=%0d want occ=8 ovf=1 drops=2",
                     occupancy, overflow, drop_count);
        end
        checks++;
        if (obs !== exp_vec()) begin
            fails++;
            $display("FAIL ovf_model got=%h want=%h", obs, exp_vec());
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_cycle !== 32'(k) || obs !== exp_vec()) begin
                fails++;
                $display("FAIL ovf_drain%0d got v=%b cyc=%0d want v=1 cyc=%0d",
                         k, out_valid, out_cycle, k);
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            fails++;
            $display("FAIL ovf_empty got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
        end
    endtask

    task automatic test_full_enq_deq();
        logic [63:0] tail_data;
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_in(1, 2'b01, 5'd1, 5'd0, r64(), 64'h0, 0);
            cycle();
        end
        tail_data = r64();
        set_in(1, 2'b01, 5'd7, 5'd0, tail_data, 64'h0, 1);
        cycle();
        set_in(0, 2'b00, 0, 0, 0, 0, 0);
        checks++;
        if (occupancy !== 4'd8 || drop_count !== 16'd1 || out_cycle !== 32'd1) begin
            fails++;
            $display("FAIL full_simul got occ=%0d drops=%0d cyc=%0d want occ=8 drops=1 cyc=1",
                     occupancy, drop_count, out_cycle);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            want = (k < 7) ? 32'(k + 1) : 32'd9;
            checks++;
            if (out_cycle !== want || obs !== exp_vec()) begin
                fails++;
                $display("FAIL full_order%0d got cyc=%0d want cyc=%0d", k, out_cycle, want);
            end
            if (k == 7) begin
                checks++;
                if (out_data[63:0] !== tail_data || out_address[4:0] !== 5'd7) begin
                    fails++;
                    $display("FAIL full_tail got data=%h addr=%0d want data=%h addr=7",
                             out_data[63:0], out_address[4:0], tail_data);
                end
            end
            cycle();
        end
    endtask

    task automatic test_enable();
        do_reset();
        set_in(1, 2'b11, 5'd3, 5'd4, r64(), r64(), 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(0, 2'b11, 5'd3, 5'd4, r64(), r64(), 0);
            cycle();
        end
        checks++;
        if (occupancy !== 4'd1 || drop_count !== 16'd0 || out_mask !== 2'b11) begin
            fails++;
            $display("FAIL en_off got occ=%0d drops=%0d mask=%b want occ=1 drops=0 mask=11",
                     occupancy, drop_count, out_mask);
        end
        set_in(1, 2'b10, 5'd0, 5'd9, r64(), r64(), 0);
        cycle();
        set_in(0, 2'b00, 0, 0, 0, 0, 1);
        cycle();
        checks++;
        if (occupancy !== 4'd1 || out_cycle !== 32'd6 || out_mask !== 2'b10 ||
            obs !== exp_vec()) begin
            fails++;
            $display("FAIL en_stamp got occ=%0d cyc=%0d mask=%b want occ=1 cyc=6 mask=10",
                     occupancy, out_cycle, out_mask);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 2'b01, 5'd2, 5'd0, r64(), 64'h0, 0);
            cycle();
        end
        set_in(0, 2'b00, 0, 0, 0, 0, 1);
        repeat (4) cycle();
        checks++;
        if (occupancy !== 4'd4 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre got occ=%0d ovf=%b want occ=4 ovf=1", occupancy, overflow);
        end
        out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0 || overflow !== 1'b0 ||
            drop_count !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset got v=%b occ=%0d ovf=%b drops=%0d want all 0",
                     out_valid, occupancy, overflow, drop_count);
        end
        set_in(1, 2'b01, 5'd6, 5'd0, r64(), 64'h0, 0);
        cycle();
        set_in(0, 2'b00, 0, 0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_cycle !== 32'd0 || occupancy !== 4'd1) begin
            fails++;
            $display("FAIL mid_restart got v=%b cyc=%0d occ=%0d want v=1 cyc=0 occ=1",
                     out_valid, out_cycle, occupancy);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            io_coreid = 8'($urandom);
            set_in($urandom_range(0, 7) != 0, 2'($urandom),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   r64(), r64(), $urandom_range(0, 9) < 4);
            cycle();
            checks++;
            if (obs !== exp_vec()) begin
                fails++;
                $display("FAIL rand%0d got=%h want=%h", n, obs, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_enq_deq();
        test_enable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/difftest_int_wb_batcher.md
Name: difftest_int_wb_batcher

Overview:
- Parametrised successor to the single-port integer-writeback difftest probe.
- Captures up to NUM_PORTS integer writebacks per cycle, timestamps them, and stores each cycle's writebacks as one entry in a DEPTH-entry FIFO.
- Entries drain over a valid/ready stream to the difftest transport, so the host side no longer needs a per-cycle DPI call.
- Sits beside the commit stage, one instance per core.

Parameters:
- NUM_PORTS, 2, writeback ports sampled per cycle (1..8)
- ADDR_W, 5, register address width
- DATA_W, 64, writeback data width
- DEPTH, 8, FIFO entries (power of two, >=2)
- FILTER_ZERO, 1, when 1, writes to address 0 are discarded
- TS_W, 32, cycle-stamp width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  global capture enable
- io_coreid  in  8  core id, sampled into each entry
- in_valid  in  NUM_PORTS  per-port writeback valid
- in_address  in  NUM_PORTS*ADDR_W  packed addresses, port i at [i*ADDR_W +: ADDR_W]
- in_data  in  NUM_PORTS*DATA_W  packed data, same packing
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_mask  out  NUM_PORTS  which ports in the head entry are live
- out_address  out  NUM_PORTS*ADDR_W  head addresses
- out_data  out  NUM_PORTS*DATA_W  head data
- out_coreid  out  8  head core id
- out_cycle  out  TS_W  cycle stamp of the head entry
- occupancy  out  $clog2(DEPTH)+1  current entry count
- overflow  out  1  sticky: at least one entry was dropped
- drop_count  out  16  dropped entries, saturating

Behaviour:
- Reset: all outputs 0; FIFO empty; cycle counter 0; overflow 0; drop_count 0. Reset mid-operation discards all entries without draining.
- Cycle counter:
  - Increments by 1 every non-reset cycle and wraps modulo 2^TS_W.
  - An entry's stamp is the counter value in its capture cycle.
- Live mask:
  - mask[i] = enable & in_valid[i] & !(FILTER_ZERO & in_address[i]==0).
  - Masked-off lanes are stored with address and data forced to 0.
- Enqueue request: asserted when mask != 0. With enable=0, or with no live lanes, nothing is stored and drop_count is unaffected.
- Dequeue: fires when out_valid & out_ready. out_* reflects the FIFO head combinationally from registers and holds stable while out_valid & !out_ready.
- Latency: an entry captured in cycle N is visible on out_valid in cycle N+1. There is no same-cycle bypass.
- Full handling:
  - Enqueue is accepted if occupancy < DEPTH, or if a dequeue fires in the same cycle.
  - Otherwise the entry is dropped: overflow is set (sticky until reset) and drop_count increments, saturating at 16'hFFFF.
- Simultaneous enqueue and dequeue:
  - Non-empty FIFO: occupancy is unchanged.
  - Empty FIFO: no dequeue is possible, so occupancy becomes 1.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. occupancy is a separate counter, ranging 0..DEPTH.
- Order: FIFO order equals capture order. Lane order inside an entry equals port index.
- No X propagation: out_* is 0 when out_valid=0.

Test Plan:
- Reset then idle 10 cycles -> out_valid=0, occupancy=0, overflow=0, drop_count=0, out_cycle=0.
- Cycle 3 (counter=3): in_valid=2'b11, addr0=5, data0=0x1111, addr1=0, data1=0x2222, FILTER_ZERO=1, out_ready=0 -> cycle 4: out_valid=1, out_mask=2'b01, out_address lane0=5, lane1=0, out_data lane1=0, out_cycle=3, occupancy=1. Then out_ready=1 for one cycle -> out_valid=0, occupancy=0.
- out_ready=0, 10 consecutive cycles with in_valid=2'b01, addr=1 (DEPTH=8) -> occupancy=8, overflow=1, drop_count=2. The first 8 stamps drain in order once out_ready=1.
- FIFO full, one cycle with both enqueue and out_ready=1 -> occupancy stays 8, drop_count unchanged, the new entry is at the tail.
- enable=0 with in_valid=2'b11 for 5 cycles -> no entries stored. Cycle counter still advances, so the next captured out_cycle is 5 higher.
- Reset asserted while occupancy=4 -> next cycle out_valid=0, occupancy=0, overflow=0, counter restarts at 0.
